pixel_write_arbiter: RTL
========================

// Module: pixel_write_arbiter
// PURPOSE
//   Merges the pixel-write streams of two sprite drawers (stair drawer = src0, player/erase drawer = src1)
//   into the single VGA-adapter write port (x, y, colour, writeEn). Whole bursts (one sprite draw or erase)
//   are granted atomically with round-robin fairness. Off-screen pixels are clipped, and a stalled burst is
//   released by a watchdog. Sits between the drawing datapaths and the vga_adapter instance.
// PARAMETERS
//   X_MAX    159  last visible column; pixels with x > X_MAX are clipped
//   Y_MAX    119  last visible row; pixels with y > Y_MAX are clipped
//   TIMEOUT  16   idle cycles (granted valid low) before the grant is forcibly released; must be >= 2
// PORTS
//   clock        in   1  system clock; only clock in the block
//   reset        in   1  synchronous, active-high reset
//   s0_valid     in   1  src0 presents a pixel
//   s0_last      in   1  src0 pixel is the final one of its burst
//   s0_x         in   8  src0 column
//   s0_y         in   7  src0 row
//   s0_colour    in   3  src0 colour (RGB)
//   s0_ready     out  1  src0 pixel consumed this cycle when s0_valid && s0_ready
//   s1_valid/s1_last/s1_x/s1_y/s1_colour/s1_ready  as s0_*, for src1
//   x            out  8  registered pixel column to vga_adapter
//   y            out  7  registered pixel row
//   colour       out  3  registered pixel colour
//   writeEn      out  1  registered plot strobe, one per accepted on-screen pixel
//   grant        out  2  one-hot current owner (00 = idle)
//   clip_count   out  8  saturating count of clipped pixels since reset
// BEHAVIOUR
//   - Reset (sync, high): state IDLE, rr pointer = src0, x=0, y=0, colour=0, writeEn=0, grant=00,
//     clip_count=0, s*_ready=0, watchdog=0. A reset mid-burst abandons the burst; nothing is flushed.
//   - States: IDLE, GRANT0, GRANT1 (encoding in package). s<i>_ready = (state == GRANT<i>), purely
//     combinational from state, so it is never asserted in IDLE or during reset.
//   - IDLE: neither valid -> IDLE. One valid -> GRANT of that source. Both valid -> GRANT of rr pointer.
//     Arbitration takes 1 cycle: the first pixel is accepted in the cycle after the grant.
//   - GRANT<i>: a transfer is s<i>_valid && s<i>_ready. On a transfer with s<i>_last=1: rr pointer = other;
//     next state = GRANT<other> if other valid this cycle, else IDLE. There is no idle bubble on handover.
//   - Watchdog: in GRANT<i>, counts consecutive cycles with s<i>_valid=0 and clears on any transfer.
//     When it reaches TIMEOUT-1, the grant is dropped with the same next-state and rr rules as a last
//     transfer. No pixel is emitted for a timeout.
//   - Output stage, latency 1: on a transfer, x/y/colour <= source fields. writeEn <= 1 iff
//     x <= X_MAX && y <= Y_MAX, else writeEn <= 0 and clip_count++ (saturates at 255).
//     Clipped pixels are still consumed (ready high). x/y/colour hold their value when writeEn=0.
//   - With no transfer, writeEn <= 0. At most one pixel per cycle; vga_adapter never back-pressures.
//   - Widths: compare unsigned x (8b) against X_MAX and y (7b) against Y_MAX. y=120..127 and
//     x=160..255 are clipped.
//   - Valid or last on the non-granted source is ignored. Its fields must be held by the source
//     until ready. The last bit is sampled only on a transfer.
//   - grant reflects the current state (GRANT0 -> 01, GRANT1 -> 10).
// STRUCTURE
//   - Shared package pixel_pkg: SCREEN_W=160, SCREEN_H=120, X_W=8, Y_W=7, COLOUR_W=3, arbiter state
//     encoding localparams, and colour constants (BLACK=3'b000, RED=3'b100).
//   - One sub-module: burst_watchdog (counter with clear/enable inputs and a TIMEOUT parameter, plus an
//     expired output), instantiated once.
//   - Everything else (state FSM, rr pointer, clip compare, output register) is inline.
// TESTING
//   - Reset: hold reset 3 cycles with both valid high -> ready=00, writeEn=0, grant=00, clip_count=0 throughout.
//   - Single burst: src0 sends 200 pixels (40x5 at x=60..99, y=40..44, colour=100, last on pixel 200)
//     -> 200 writeEn pulses, each 1 cycle after its transfer, with matching x/y; grant=01, then 00.
//   - Contention: both valid in IDLE after reset -> src0 granted first; at src0 last, src1 granted the
//     next cycle with no bubble; the next simultaneous request goes to src0 again (alternation).
//   - Clipping: src1 sends x=158,159,160 at y=119, then x=10 at y=120 -> writeEn 1,1,0,0 and
//     clip_count=2; all 4 are consumed.
//   - Watchdog (TIMEOUT=16): src0 sends 3 pixels, then valid low for 16 cycles -> grant drops to 00 and
//     any pending src1 is granted; no writeEn during the stall.
//   - Reset mid-burst: assert reset at pixel 50 of a src1 burst -> next cycle ready=00, writeEn=0; after
//     release, src0 wins a simultaneous request (rr restored to src0).

Source files
------------

// File: rtl/pixel_pkg.sv
// Shared screen geometry, arbiter state encoding and colour constants.
// Imported by the pixel write arbiter and its bench.
package pixel_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_GRANT0 = 2'b01;
  localparam logic [1:0] ST_GRANT1 = 2'b10;

  localparam logic [COLOUR_W-1:0] BLACK = 3'b000;
  localparam logic [COLOUR_W-1:0] RED   = 3'b100;

endpackage

// File: rtl/burst_watchdog.sv
// Idle-cycle counter for a granted burst.
// Ports: clock, reset, clear, enable (idle cycle), expired (limit hit).
module burst_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // Fires on the TIMEOUT-th consecutive idle cycle.
  assign expired = enable && (count == LIMIT);

  always_ff @(posedge clock) begin
    if (reset || clear || expired)
      count <= '0;
    else if (enable)
      count <= count + CW'(1);
  end

endmodule

// File: rtl/pixel_write_arbiter.sv
// Two-source burst arbiter onto the VGA adapter write port.
// Ports: s0_*/s1_* pixel streams in; x, y, colour, writeEn, grant, clip_count out.
module pixel_write_arbiter
  import pixel_pkg::*;
#(
  parameter int X_MAX   = SCREEN_W - 1,
  parameter int Y_MAX   = SCREEN_H - 1,
  parameter int TIMEOUT = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                s0_valid,
  input  logic                s0_last,
  input  logic [X_W-1:0]      s0_x,
  input  logic [Y_W-1:0]      s0_y,
  input  logic [COLOUR_W-1:0] s0_colour,
  output logic                s0_ready,
  input  logic                s1_valid,
  input  logic                s1_last,
  input  logic [X_W-1:0]      s1_x,
  input  logic [Y_W-1:0]      s1_y,
  input  logic [COLOUR_W-1:0] s1_colour,
  output logic                s1_ready,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                writeEn,
  output logic [1:0]          grant,
  output logic [7:0]          clip_count
);

  localparam logic [X_W-1:0] XM = X_W'(X_MAX);
  localparam logic [Y_W-1:0] YM = Y_W'(Y_MAX);

  logic [1:0] state, state_nx;
  logic       rr, rr_nx;
  logic       g0, g1;
  logic       xfer0, xfer1, xfer;
  logic       wd_en, wd_clr, wd_exp;
  logic       done0, done1;
  logic [X_W-1:0]      sel_x;
  logic [Y_W-1:0]      sel_y;
  logic [COLOUR_W-1:0] sel_c;
  logic                on_screen;

  assign g0 = (state == ST_GRANT0);
  assign g1 = (state == ST_GRANT1);

  assign s0_ready = g0;
  assign s1_ready = g1;
  assign grant    = {g1, g0};

  assign xfer0 = s0_valid && s0_ready;
  assign xfer1 = s1_valid && s1_ready;
  assign xfer  = xfer0 || xfer1;

  assign wd_en  = (g0 && !s0_valid) || (g1 && !s1_valid);
  assign wd_clr = xfer || !(g0 || g1);

  burst_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wd (
    .clock   (clock),
    .reset   (reset),
    .clear   (wd_clr),
    .enable  (wd_en),
    .expired (wd_exp)
  );

  // A stalled burst ends exactly like a last transfer.
  assign done0 = g0 && ((xfer0 && s0_last) || wd_exp);
  assign done1 = g1 && ((xfer1 && s1_last) || wd_exp);

  always_comb begin
    state_nx = state;
    rr_nx    = rr;
    unique case (1'b1)
      g0: begin
        if (done0) begin
          rr_nx    = 1'b1;
          state_nx = s1_valid ? ST_GRANT1 : ST_IDLE;
        end
      end
      g1: begin
        if (done1) begin
          rr_nx    = 1'b0;
          state_nx = s0_valid ? ST_GRANT0 : ST_IDLE;
        end
      end
      default: begin
        if (s0_valid && s1_valid)
          state_nx = rr ? ST_GRANT1 : ST_GRANT0;
        else if (s0_valid)
          state_nx = ST_GRANT0;
        else if (s1_valid)
          state_nx = ST_GRANT1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
      rr    <= 1'b0;
    end else begin
      state <= state_nx;
      rr    <= rr_nx;
    end
  end

  assign sel_x = xfer1 ? s1_x      : s0_x;
  assign sel_y = xfer1 ? s1_y      : s0_y;
  assign sel_c = xfer1 ? s1_colour : s0_colour;

  assign on_screen = (sel_x <= XM) && (sel_y <= YM);

  // Position registers only move on a plotted pixel.
  always_ff @(posedge clock) begin
    if (reset) begin
      x          <= '0;
      y          <= '0;
      colour     <= BLACK;
      writeEn    <= 1'b0;
      clip_count <= '0;
    end else begin
      writeEn <= xfer && on_screen;
      if (xfer && on_screen) begin
        x      <= sel_x;
        y      <= sel_y;
        colour <= sel_c;
      end
      if (xfer && !on_screen && (clip_count != 8'hFF))
        clip_count <= clip_count + 8'd1;
    end
  end

endmodule
